kyber_operand_loader: RTL and testbench

- Word-serial front end that sits directly upstream of Kyber512_pre_post_hash_ENC.
- Accepts 32-bit words from the AXI slave data path and assembles them into the 256-bit seed, the 6400-bit public key and the 5888-bit ciphertext.
- Tracks which operands are complete and issues the single-cycle enable/mode launch to the hash stage only when the required operands are present.

---
 rtl/kyber_pkg.sv | 23 ++
 rtl/kyber_word_shreg.sv | 24 ++
 rtl/kyber_operand_loader.sv | 163 ++++++++++++++++
 tb/tb_kyber_operand_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared sizes, target encodings and FSM states for the Kyber operand loader.
package kyber_pkg;

    localparam int KYBER_WORD_W    = 32;
    localparam int KYBER_SEED_BITS = 256;
    localparam int KYBER_PK_BITS   = 6400;
    localparam int KYBER_CT_BITS   = 5888;

    localparam int KYBER_SEED_WORDS = KYBER_SEED_BITS / KYBER_WORD_W;  // 8
    localparam int KYBER_PK_WORDS   = KYBER_PK_BITS / KYBER_WORD_W;    // 200
    localparam int KYBER_CT_WORDS   = KYBER_CT_BITS / KYBER_WORD_W;    // 184

    localparam logic [1:0] SEL_SEED = 2'd0;
    localparam logic [1:0] SEL_PK   = 2'd1;
    localparam logic [1:0] SEL_CT   = 2'd2;
    localparam logic [1:0] SEL_BAD  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/kyber_word_shreg.sv
// One operand register: shifts a word in at the LSB end, so the first word
// loaded ends up most significant.
module kyber_word_shreg
    import kyber_pkg::*;
#(
    parameter int N      = KYBER_SEED_BITS,
    parameter int WORD_W = KYBER_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic [N-1:0]      q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (shift) begin
            q <= {q[N-WORD_W-1:0], din};
        end
    end

endmodule

// File: rtl/kyber_operand_loader.sv
// Word-serial loader for seed / public key / ciphertext, with completion
// tracking and a guarded single-cycle launch into the pre/post hash stage.
module kyber_operand_loader
    import kyber_pkg::*;
#(
    parameter int WORD_W    = KYBER_WORD_W,
    parameter int SEED_BITS = KYBER_SEED_BITS,
    parameter int PK_BITS   = KYBER_PK_BITS,
    parameter int CT_BITS   = KYBER_CT_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [1:0]           i_sel,
    input  logic [WORD_W-1:0]    i_wdata,
    input  logic                 i_wvalid,
    output logic                 o_wready,
    input  logic                 i_launch,
    input  logic                 i_mode,
    input  logic                 i_err_clr,
    output logic [SEED_BITS-1:0] o_buf,
    output logic [PK_BITS-1:0]   o_Pk,
    output logic [CT_BITS-1:0]   o_Ct,
    output logic                 o_seed_vld,
    output logic                 o_pk_vld,
    output logic                 o_ct_vld,
    output logic                 o_load_done,
    output logic                 o_busy,
    output logic                 o_enable,
    output logic                 o_mode,
    output logic                 o_err
);

    localparam logic [7:0] SEED_LAST = 8'(SEED_BITS / WORD_W - 1);
    localparam logic [7:0] PK_LAST   = 8'(PK_BITS / WORD_W - 1);
    localparam logic [7:0] CT_LAST   = 8'(CT_BITS / WORD_W - 1);

    state_t     state;
    logic [1:0] target;
    logic [7:0] count;
    logic [2:0] valid;
    logic [7:0] last_count;
    logic       in_load;
    logic       start_ok;
    logic       start_bad;
    logic       accept;
    logic       load_last;
    logic       launch_cond;
    logic       launch_fire;
    logic       launch_bad;
    logic       err_set;

    always_comb begin
        last_count = SEED_LAST;
        case (target)
            SEL_PK:  last_count = PK_LAST;
            SEL_CT:  last_count = CT_LAST;
            default: last_count = SEED_LAST;
        endcase
    end

    assign in_load   = (state == ST_LOAD);
    assign o_wready  = in_load;
    assign o_busy    = in_load;
    assign start_ok  = i_start && (i_sel != SEL_BAD);
    assign start_bad = i_start && (i_sel == SEL_BAD);
    // A start in the same cycle takes priority, so that word is dropped.
    assign accept    = in_load && i_wvalid && !i_start;
    assign load_last = accept && (count == last_count);

    assign launch_cond = i_mode ? o_ct_vld : (o_seed_vld && o_pk_vld);
    assign launch_fire = i_launch && !in_load && !i_start && launch_cond;
    assign launch_bad  = i_launch && (in_load || i_start || !launch_cond);
    assign err_set     = start_bad || launch_bad;

    assign o_seed_vld = valid[SEL_SEED];
    assign o_pk_vld   = valid[SEL_PK];
    assign o_ct_vld   = valid[SEL_CT];

    kyber_word_shreg #(.N(SEED_BITS), .WORD_W(WORD_W)) u_seed (
        .clk   (clk),
        .reset (reset),
        .shift (accept && (target == SEL_SEED)),
        .din   (i_wdata),
        .q     (o_buf)
    );

    kyber_word_shreg #(.N(PK_BITS), .WORD_W(WORD_W)) u_pk (
        .clk   (clk),
        .reset (reset),
        .shift (accept && (target == SEL_PK)),
        .din   (i_wdata),
        .q     (o_Pk)
    );

    kyber_word_shreg #(.N(CT_BITS), .WORD_W(WORD_W)) u_ct (
        .clk   (clk),
        .reset (reset),
        .shift (accept && (target == SEL_CT)),
        .din   (i_wdata),
        .q     (o_Ct)
    );

    // Per-target valid flags: a (re)start invalidates, the final word validates.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_valid
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid[gi] <= 1'b0;
                end else if (start_ok && (i_sel == 2'(gi))) begin
                    valid[gi] <= 1'b0;
                end else if (load_last && (target == 2'(gi))) begin
                    valid[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            target      <= SEL_SEED;
            count       <= '0;
            o_load_done <= 1'b0;
            o_enable    <= 1'b0;
            o_mode      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_load_done <= 1'b0;
            o_enable    <= 1'b0;

            if (err_set) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end

            if (launch_fire) begin
                o_mode   <= i_mode;
                o_enable <= 1'b1;
            end

            if (start_ok) begin
                state  <= ST_LOAD;
                target <= i_sel;
                count  <= '0;
            end else if (start_bad) begin
                state <= ST_IDLE;
                count <= '0;
            end else if (accept) begin
                if (load_last) begin
                    state       <= ST_IDLE;
                    count       <= '0;
                    o_load_done <= 1'b1;
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kyber_operand_loader.sv
// Self-checking bench: completed loads and launches are scoreboarded and
// compared when the loader pulses o_load_done / o_enable.
module tb_kyber_operand_loader;
    import kyber_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [1:0]    i_sel;
    logic [31:0]   i_wdata;
    logic          i_wvalid;
    logic          o_wready;
    logic          i_launch;
    logic          i_mode;
    logic          i_err_clr;
    logic [255:0]  o_buf;
    logic [6399:0] o_Pk;
    logic [5887:0] o_Ct;
    logic          o_seed_vld, o_pk_vld, o_ct_vld;
    logic          o_load_done, o_busy, o_enable, o_mode, o_err;

    kyber_operand_loader dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_sel       (i_sel),
        .i_wdata     (i_wdata),
        .i_wvalid    (i_wvalid),
        .o_wready    (o_wready),
        .i_launch    (i_launch),
        .i_mode      (i_mode),
        .i_err_clr   (i_err_clr),
        .o_buf       (o_buf),
        .o_Pk        (o_Pk),
        .o_Ct        (o_Ct),
        .o_seed_vld  (o_seed_vld),
        .o_pk_vld    (o_pk_vld),
        .o_ct_vld    (o_ct_vld),
        .o_load_done (o_load_done),
        .o_busy      (o_busy),
        .o_enable    (o_enable),
        .o_mode      (o_mode),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    sel;
        logic [6399:0] val;
    } load_exp_t;

    load_exp_t     load_q[$];
    logic          mode_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [6399:0] exp_seed = '0;
    logic [6399:0] exp_pk   = '0;
    logic [6399:0] exp_ct   = '0;
    load_exp_t     mon_e;
    logic [6399:0] mon_got;
    logic          mon_m;

    // Scoreboard side: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (o_load_done === 1'b1) begin
            n_checks++;
            if (load_q.size() == 0) begin
                $display("FAIL load_done_unexpected: load_done=1 required=0");
            end else begin
                mon_e   = load_q.pop_front();
                mon_got = '0;
                case (mon_e.sel)
                    SEL_SEED: mon_got[255:0]  = o_buf;
                    SEL_PK:   mon_got         = o_Pk;
                    default:  mon_got[5887:0] = o_Ct;
                endcase
                if (mon_got !== mon_e.val)
                    $display("FAIL load_value sel=%0d: got top=%h low=%h required top=%h low=%h",
                             mon_e.sel, mon_got[6399:6368], mon_got[31:0],
                             mon_e.val[6399:6368], mon_e.val[31:0]);
                else begin
                    n_pass++;
                    $display("load sel=%0d complete, low word %h", mon_e.sel, mon_got[31:0]);
                end
            end
        end
        if (o_enable === 1'b1) begin
            n_checks++;
            if (mode_q.size() == 0) begin
                $display("FAIL enable_unexpected: enable=1 required=0");
            end else begin
                mon_m = mode_q.pop_front();
                if (o_mode !== mon_m)
                    $display("FAIL launch_mode: mode=%0b required=%0b", o_mode, mon_m);
                else begin
                    n_pass++;
                    $display("launch mode=%0b", o_mode);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] sel);
        i_start = 1'b1;
        i_sel   = sel;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        i_wvalid = 1'b1;
        i_wdata  = w;
        tick();
        i_wvalid = 1'b0;
    endtask

    task automatic launch(input logic m);
        i_launch = 1'b1;
        i_mode   = m;
        tick();
        i_launch = 1'b0;
    endtask

    task automatic clear_err();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++;
        if ({o_buf != 0, o_Pk != 0, o_Ct != 0, o_seed_vld, o_pk_vld, o_ct_vld,
             o_load_done, o_busy, o_wready, o_enable, o_mode, o_err} !== 12'b0)
            $display("FAIL reset_state: flags=%b required=0",
                     {o_seed_vld, o_pk_vld, o_ct_vld, o_load_done, o_busy, o_wready, o_enable, o_mode, o_err});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_seed();
        logic [31:0]   sw[8] = '{32'hd3d4b6b2, 32'h92b3acd4, 32'h8f52979d, 32'hc1442096,
                                 32'he2fd44f5, 32'h2f384e7d, 32'h87690f67, 32'h924fdd25};
        logic [6399:0] acc = '0;
        for (int i = 0; i < 8; i++) acc = {acc[6367:0], sw[i]};
        load_q.push_back('{SEL_SEED, acc});
        exp_seed = acc;
        start(SEL_SEED);
        n_checks++;
        if (o_busy !== 1'b1 || o_wready !== 1'b1)
            $display("FAIL seed_busy: busy=%b wready=%b required 1 1", o_busy, o_wready);
        else n_pass++;
        for (int i = 0; i < 7; i++) send_word(sw[i]);
        n_checks++;
        if (o_load_done !== 1'b0 || o_seed_vld !== 1'b0)
            $display("FAIL seed_early_done: done=%b vld=%b required 0 0", o_load_done, o_seed_vld);
        else n_pass++;
        send_word(sw[7]);
        n_checks++;
        if (o_load_done !== 1'b1 || o_seed_vld !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL seed_done: done=%b vld=%b busy=%b required 1 1 0", o_load_done, o_seed_vld, o_busy);
        else n_pass++;
        n_checks++;
        if (o_buf !== 256'hd3d4b6b2_92b3acd4_8f52979d_c1442096_e2fd44f5_2f384e7d_87690f67_924fdd25)
            $display("FAIL seed_buf: buf=%h", o_buf);
        else n_pass++;
        tick();
        n_checks++;
        if (o_load_done !== 1'b0)
            $display("FAIL seed_done_width: done=%b required 0", o_load_done);
        else n_pass++;
    endtask

    task automatic test_pk();
        logic [31:0]   pw[200];
        logic [6399:0] acc = '0;
        for (int i = 0; i < 200; i++) pw[i] = $urandom;
        pw[0]   = 32'hc4794b69;
        pw[199] = 32'h002c2672;
        for (int i = 0; i < 200; i++) acc = {acc[6367:0], pw[i]};
        load_q.push_back('{SEL_PK, acc});
        exp_pk = acc;
        start(SEL_PK);
        for (int i = 0; i < 200; i++) begin
            if (i > 0 && i % 50 == 0) repeat (3) tick();
            send_word(pw[i]);
        end
        n_checks++;
        if (o_Pk[6399:6368] !== 32'hc4794b69 || o_Pk[31:0] !== 32'h002c2672 || o_pk_vld !== 1'b1)
            $display("FAIL pk_load: top=%h low=%h vld=%b required c4794b69 002c2672 1",
                     o_Pk[6399:6368], o_Pk[31:0], o_pk_vld);
        else n_pass++;
        mode_q.push_back(1'b0);
        launch(1'b0);
        n_checks++;
        if (o_enable !== 1'b1 || o_mode !== 1'b0 || o_err !== 1'b0)
            $display("FAIL pk_launch: enable=%b mode=%b err=%b required 1 0 0", o_enable, o_mode, o_err);
        else n_pass++;
        tick();
        n_checks++;
        if (o_enable !== 1'b0 || o_seed_vld !== 1'b1 || o_pk_vld !== 1'b1)
            $display("FAIL pk_launch_pulse: enable=%b seed_vld=%b pk_vld=%b required 0 1 1",
                     o_enable, o_seed_vld, o_pk_vld);
        else n_pass++;
    endtask

    task automatic test_launch_no_ct();
        launch(1'b1);
        n_checks++;
        if (o_err !== 1'b1 || o_enable !== 1'b0)
            $display("FAIL launch_no_ct: err=%b enable=%b required 1 0", o_err, o_enable);
        else n_pass++;
        clear_err();
        n_checks++;
        if (o_err !== 1'b0)
            $display("FAIL err_clr: err=%b required 0", o_err);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0]   cw[184];
        logic [6399:0] acc = '0;
        start(SEL_CT);
        for (int i = 0; i < 100; i++) send_word($urandom);
        i_start  = 1'b1;
        i_sel    = SEL_CT;
        i_wvalid = 1'b1;
        i_wdata  = 32'hdeadbeef;
        tick();
        i_start  = 1'b0;
        i_wvalid = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1 || o_ct_vld !== 1'b0 || o_err !== 1'b0)
            $display("FAIL abort_restart: busy=%b ct_vld=%b err=%b required 1 0 0", o_busy, o_ct_vld, o_err);
        else n_pass++;
        for (int i = 0; i < 184; i++) cw[i] = $urandom;
        cw[0] = 32'haadc275d;
        for (int i = 0; i < 184; i++) acc = {acc[6367:0], cw[i]};
        load_q.push_back('{SEL_CT, acc});
        exp_ct = acc;
        for (int i = 0; i < 183; i++) send_word(cw[i]);
        n_checks++;
        if (o_ct_vld !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL abort_count: ct_vld=%b busy=%b required 0 1 after 183 words", o_ct_vld, o_busy);
        else n_pass++;
        send_word(cw[183]);
        n_checks++;
        if (o_Ct[5887:5856] !== 32'haadc275d || o_ct_vld !== 1'b1)
            $display("FAIL abort_ct: top=%h vld=%b required aadc275d 1", o_Ct[5887:5856], o_ct_vld);
        else n_pass++;
        mode_q.push_back(1'b1);
        launch(1'b1);
        n_checks++;
        if (o_enable !== 1'b1 || o_mode !== 1'b1)
            $display("FAIL ct_launch: enable=%b mode=%b required 1 1", o_enable, o_mode);
        else n_pass++;
    endtask

    task automatic test_illegal();
        start(SEL_BAD);
        n_checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_wready !== 1'b0)
            $display("FAIL illegal_sel: err=%b busy=%b wready=%b required 1 0 0", o_err, o_busy, o_wready);
        else n_pass++;
        clear_err();
        for (int i = 0; i < 3; i++) send_word($urandom);
        n_checks++;
        if (o_buf !== exp_seed[255:0] || o_Pk !== exp_pk || o_Ct !== exp_ct[5887:0] || o_err !== 1'b0)
            $display("FAIL idle_words: buf_low=%h pk_low=%h ct_low=%h err=%b required %h %h %h 0",
                     o_buf[31:0], o_Pk[31:0], o_Ct[31:0], o_err, exp_seed[31:0], exp_pk[31:0], exp_ct[31:0]);
        else n_pass++;
        // Clear and new error together: the error must remain set.
        i_err_clr = 1'b1;
        start(SEL_BAD);
        i_err_clr = 1'b0;
        n_checks++;
        if (o_err !== 1'b1)
            $display("FAIL err_set_wins: err=%b required 1", o_err);
        else n_pass++;
        clear_err();
        i_launch = 1'b1;
        i_mode   = 1'b0;
        start(SEL_SEED);
        i_launch = 1'b0;
        n_checks++;
        if (o_err !== 1'b1 || o_enable !== 1'b0 || o_busy !== 1'b1 || o_seed_vld !== 1'b0)
            $display("FAIL start_and_launch: err=%b enable=%b busy=%b seed_vld=%b required 1 0 1 0",
                     o_err, o_enable, o_busy, o_seed_vld);
        else n_pass++;
        clear_err();
        launch(1'b0);
        n_checks++;
        if (o_err !== 1'b1 || o_enable !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL launch_in_load: err=%b enable=%b busy=%b required 1 0 1", o_err, o_enable, o_busy);
        else n_pass++;
        clear_err();
        start(SEL_BAD);
        n_checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_seed_vld !== 1'b0)
            $display("FAIL illegal_in_load: err=%b busy=%b seed_vld=%b required 1 0 0", o_err, o_busy, o_seed_vld);
        else n_pass++;
        clear_err();
    endtask

    task automatic test_reset_midload();
        start(SEL_PK);
        for (int i = 0; i < 4; i++) send_word($urandom);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({o_buf != 0, o_Pk != 0, o_Ct != 0, o_seed_vld, o_pk_vld, o_ct_vld,
             o_load_done, o_busy, o_wready, o_enable, o_mode, o_err} !== 12'b0)
            $display("FAIL reset_midload: flags=%b mode=%b required all 0",
                     {o_seed_vld, o_pk_vld, o_ct_vld, o_load_done, o_busy, o_wready, o_enable, o_err}, o_mode);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        tick();
        launch(1'b0);
        n_checks++;
        if (o_err !== 1'b1 || o_enable !== 1'b0)
            $display("FAIL launch_after_reset: err=%b enable=%b required 1 0", o_err, o_enable);
        else n_pass++;
    endtask

    initial begin
        i_start   = 1'b0;
        i_sel     = 2'd0;
        i_wdata   = '0;
        i_wvalid  = 1'b0;
        i_launch  = 1'b0;
        i_mode    = 1'b0;
        i_err_clr = 1'b0;
        test_reset();
        test_seed();
        test_pk();
        test_launch_no_ct();
        test_abort();
        test_illegal();
        test_reset_midload();
        tick();
        n_checks++;
        if (load_q.size() != 0 || mode_q.size() != 0)
            $display("FAIL scoreboard_drain: loads_left=%0d launches_left=%0d required 0 0",
                     load_q.size(), mode_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
